// File: rtl/gate_cell_selftest_seq.sv
// Self-test sequencer for the shared logic cells: walks every operand vector through each
// cell, compares against a golden truth table and reports progress, busy and fail on io_out.
module gate_cell_selftest_seq #(
    parameter int NUM_GATES = 7,
    parameter int VEC_BITS  = 3   // io_out[5:3] and the 8-entry truth tables assume 3
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [2:0]          LAST_GATE = 3'(NUM_GATES - 1);
    localparam logic [2:0]          DONE_IDX  = 3'd7;
    localparam logic [VEC_BITS-1:0] LAST_OP   = {VEC_BITS{1'b1}};

    logic clk, rst_n, start, hold, inject, stop_on_fail;
    logic unused_io;

    assign clk          = io_in[0];
    assign rst_n        = io_in[1];
    assign start        = io_in[2];
    assign hold         = io_in[3];
    assign inject       = io_in[4];
    assign stop_on_fail = io_in[5];
    assign unused_io    = &{1'b0, io_in[7:6]};

    state_t              state, state_next;
    logic [2:0]          gate_idx, gate_next;
    logic [VEC_BITS-1:0] op, op_next;
    logic                fail, fail_next;
    logic                start_q, start_rise;
    logic                busy;

    assign start_rise = start & ~start_q;
    assign busy       = (state == S_APPLY) || (state == S_CHECK);
    assign io_out     = {fail, busy, op, gate_idx};

    // Cells under test, all driven continuously from the operand vector.
    logic a, b, s;
    logic and_out, xor_out, nand_out, not_out, buf_out, mux_out, dff_q;

    assign a        = op[0];
    assign b        = op[1];
    assign s        = op[2];
    assign and_out  = a & b;
    assign xor_out  = a ^ b;
    assign nand_out = ~(a & b);
    assign not_out  = ~a;
    assign buf_out  = a;
    assign mux_out  = s ? b : a;

    // The flop cell keeps clocking through hold; its d is stable then, so the check stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dff_q <= 1'b0;
        else        dff_q <= a;
    end

    logic       cell_out, expected, mismatch;
    logic [7:0] golden;

    // Golden outputs indexed by op; bit n is the expected output for op == n.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cell_out = 1'b0;
        golden   = 8'h00;
        case (gate_idx)
            3'd0: begin cell_out = and_out;  golden = 8'b1000_1000; end
            3'd1: begin cell_out = xor_out;  golden = 8'b0110_0110; end
            3'd2: begin cell_out = nand_out; golden = 8'b0111_0111; end
            3'd3: begin cell_out = not_out;  golden = 8'b0101_0101; end
            3'd4: begin cell_out = buf_out;  golden = 8'b1010_1010; end
            3'd5: begin cell_out = mux_out;  golden = 8'b1100_1010; end
            3'd6: begin cell_out = dff_q;    golden = 8'b1010_1010; end
            default: ;
        endcase
        expected = golden[op];
        mismatch = cell_out != (expected ^ inject);
    end

    always_comb begin
        state_next = state;
        gate_next  = gate_idx;
        op_next    = op;
        fail_next  = fail;
        case (state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start_rise) begin
                    state_next = S_APPLY;
                    gate_next  = 3'd0;
                    op_next    = '0;
                    fail_next  = 1'b0;
                end
            end
            S_APPLY: state_next = S_CHECK;
            S_CHECK: begin
                if (mismatch) fail_next = 1'b1;
                if (mismatch && stop_on_fail) begin
                    state_next = S_FAULT;
                end else if (op == LAST_OP) begin
                    op_next = '0;
                    if (gate_idx == LAST_GATE) begin
                        state_next = S_DONE;
                        gate_next  = DONE_IDX;
                    end else begin
                        state_next = S_APPLY;
                        gate_next  = gate_idx + 3'd1;
                    end
                end else begin
                    state_next = S_APPLY;
                    op_next    = op + VEC_BITS'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // start_q tracks the pin even during hold, so an edge arriving under hold is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            gate_idx <= 3'd0;
            op       <= '0;
            fail     <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            start_q <= start;
            if (!hold) begin
                state    <= state_next;
                gate_idx <= gate_next;
                op       <= op_next;
                fail     <= fail_next;
            end
        end
    end

endmodule

// File: tb/tb_gate_cell_selftest_seq.sv
// Bench for gate_cell_selftest_seq: directed scenarios plus random pin activity, every cycle
// compared against a run-step model (step k -> gate k/16, op (k/2)%8, even k = apply).
module tb_gate_cell_selftest_seq;

    localparam int STEPS_PER_GATE = 16;
    localparam int TOTAL_STEPS    = 112;

    logic       clk = 1'b0;
    logic       rst_n, start, hold, inject, stop_on_fail;
    logic [1:0] spare;
    logic [7:0] io_in, io_out;

    assign io_in = {spare, stop_on_fail, inject, hold, start, rst_n, clk};

    gate_cell_selftest_seq dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int busy_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 25) $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference model: a run is a count k of completed half-steps over the whole sweep.
    typedef enum {M_IDLE, M_RUN, M_DONE, M_FAULT} mmode_t;
    mmode_t m_mode;
    int     m_k;
    logic   m_fail, m_sq;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_k    = 0;
        m_fail = 1'b0;
        m_sq   = 1'b0;
    endtask

    // Every cell is ideal, so a CHECK step mismatches exactly when inject is high.
    task automatic model_step(input logic st, input logic h, input logic inj, input logic sof);
        logic rise;
        rise = st && !m_sq;
        m_sq = st;
        if (!h) begin
            case (m_mode)
                M_RUN: begin
                    if (m_k % 2 == 0) begin
                        m_k++;
                    end else begin
                        if (inj) m_fail = 1'b1;
                        if (inj && sof)               m_mode = M_FAULT;
                        else if (m_k == TOTAL_STEPS - 1) m_mode = M_DONE;
                        else                          m_k++;
                    end
                end
                default: begin
                    if (rise) begin
                        m_mode = M_RUN;
                        m_k    = 0;
                        m_fail = 1'b0;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [2:0] g, o;
        logic       bsy;
        g   = 3'(m_k / STEPS_PER_GATE);
        o   = 3'((m_k / 2) % 8);
        bsy = 1'b0;
        case (m_mode)
            M_IDLE:  begin g = 3'd0; o = 3'd0; end
            M_RUN:   bsy = 1'b1;
            M_DONE:  begin g = 3'd7; o = 3'd0; end
            default: ;
        endcase
        return {m_fail, bsy, o, g};
    endfunction

    // Called at a falling edge: drive, let the rising edge act, then compare at the next fall.
    task automatic cycle(input logic st, input logic h, input logic inj, input logic sof);
        start = st; hold = h; inject = inj; stop_on_fail = sof;
        @(posedge clk);
        model_step(st, h, inj, sof);
        @(negedge clk);
        check("cycle", io_out, model_out());
        if (io_out[6]) busy_cnt++;
    endtask

    task automatic run_idle(input int n, input logic inj, input logic sof);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, inj, sof);
    endtask

    task automatic run_to_step(input int k);
        int guard = 0;
        while (!(m_mode == M_RUN && m_k == k) && guard < 300) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
    endtask

    logic [7:0] frozen;

    initial begin
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; inject = 1'b0; stop_on_fail = 1'b0; spare = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset", io_out, 8'h00);
        rst_n = 1'b1;
        run_idle(3, 1'b0, 1'b0);

        // Clean run: exactly 112 busy cycles, ends at idx 7, fail clear.
        busy_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("first_apply", io_out, 8'h40);
        run_idle(130, 1'b0, 1'b0);
        check("clean_len", busy_cnt, 112);
        check("clean_end", io_out, 8'h07);

        // Second start edge while busy is ignored.
        busy_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_idle(30, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_idle(110, 1'b0, 1'b0);
        check("restart_len", busy_cnt, 112);
        check("restart_end", io_out, 8'h07);

        // inject + stop_on_fail: halt at the very first check, then a clean rerun.
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("fault_out", io_out, 8'h80);
        run_idle(5, 1'b1, 1'b1);
        check("fault_held", io_out, 8'h80);
        busy_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_idle(120, 1'b0, 1'b0);
        check("after_fault_len", busy_cnt, 112);
        check("after_fault_end", io_out, 8'h07);

        // inject without stop: full-length run, fail sticky until the next start.
        busy_cnt = 0;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        run_idle(120, 1'b1, 1'b0);
        check("inject_len", busy_cnt, 112);
        check("inject_end", io_out, 8'h87);
        run_idle(6, 1'b0, 1'b0);
        check("fail_sticky", io_out, 8'h87);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("fail_clear", io_out, 8'h40);
        run_idle(120, 1'b0, 1'b0);

        // Hold for 10 cycles at gate 6, op 3: outputs freeze, run stretches to 122.
        busy_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_to_step(6 * STEPS_PER_GATE + 3 * 2);
        frozen = io_out;
        check("hold_point", frozen, 8'h5E);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            check("hold_frozen", io_out, frozen);
        end
        run_idle(40, 1'b0, 1'b0);
        check("hold_len", busy_cnt, 122);
        check("hold_end", io_out, 8'h07);

        // Asynchronous reset mid-run at gate 2 clears io_out before any clock edge.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_to_step(2 * STEPS_PER_GATE + 5);
        #2 rst_n = 1'b0;
        #1 check("rst_async", io_out, 8'h00);
        model_reset();
        @(negedge clk);
        check("rst_held", io_out, 8'h00);
        rst_n = 1'b1;
        run_idle(5, 1'b0, 1'b0);
        check("rst_idle", io_out, 8'h00);

        // Random pin activity against the model.
        for (int i = 0; i < 1500; i++) begin
            spare = 2'($urandom);
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 31) == 0, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
